// File: rtl/difi_pkg.sv
// Shared types and constants for the DIFI packet arbiter slice.
package difi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CTXT = 2'd1,
        PYLD = 2'd2
    } arb_state_t;

    localparam int CTXT_TUSER_W = 4;

    // CHDR packet types of data packets (without / with timestamp).
    localparam logic [2:0] CHDR_PKT_TYPE_DATA    = 3'd6;
    localparam logic [2:0] CHDR_PKT_TYPE_DATA_TS = 3'd7;

    function automatic logic is_data_pkt_type(input logic [2:0] pkt_type);
        return (pkt_type == CHDR_PKT_TYPE_DATA) || (pkt_type == CHDR_PKT_TYPE_DATA_TS);
    endfunction

endpackage

// File: rtl/difi_rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning ptr, ptr+1, ... mod N.
module difi_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     pick,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    always_comb begin
        int cand;
        // NOTE: every output gets a default before the scan so no path leaves it unassigned (no latch).
        pick = '0;
        idx  = '0;
        vld  = 1'b0;
        cand = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!vld && req[cand]) begin
                vld        = 1'b1;
                pick[cand] = 1'b1;
                idx        = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/difi_pkt_arbiter.sv
// Packet-level round-robin arbiter sharing one DIFI context/payload output among N_REQ requesters.
module difi_pkt_arbiter
    import difi_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int CHDR_W = 64,
    parameter int ITEM_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                             axis_data_clk,
    input  logic                             axis_data_rst_n,
    input  logic [N_REQ-1:0]                 en_mask,
    input  logic [N_REQ*CHDR_W-1:0]          s_ctxt_tdata,
    input  logic [N_REQ*CTXT_TUSER_W-1:0]    s_ctxt_tuser,
    input  logic [N_REQ-1:0]                 s_ctxt_tlast,
    input  logic [N_REQ-1:0]                 s_ctxt_tvalid,
    output logic [N_REQ-1:0]                 s_ctxt_tready,
    input  logic [N_REQ*ITEM_W-1:0]          s_pyld_tdata,
    input  logic [N_REQ-1:0]                 s_pyld_tkeep,
    input  logic [N_REQ-1:0]                 s_pyld_tlast,
    input  logic [N_REQ-1:0]                 s_pyld_tvalid,
    output logic [N_REQ-1:0]                 s_pyld_tready,
    output logic [CHDR_W-1:0]                m_ctxt_tdata,
    output logic [CTXT_TUSER_W-1:0]          m_ctxt_tuser,
    output logic                             m_ctxt_tlast,
    output logic                             m_ctxt_tvalid,
    input  logic                             m_ctxt_tready,
    output logic [ITEM_W-1:0]                m_pyld_tdata,
    output logic                             m_pyld_tkeep,
    output logic                             m_pyld_tlast,
    output logic                             m_pyld_tvalid,
    input  logic                             m_pyld_tready,
    output logic [N_REQ-1:0]                 grant,
    output logic                             busy,
    output logic [CNT_W-1:0]                 pkt_cnt
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t        state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;

    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  pick_oh;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_vld;

    logic [CHDR_W-1:0]       sel_ctxt_tdata;
    logic [CTXT_TUSER_W-1:0] sel_ctxt_tuser;
    logic                    sel_ctxt_tlast;
    logic                    sel_ctxt_tvalid;
    logic [ITEM_W-1:0]       sel_pyld_tdata;
    logic                    sel_pyld_tkeep;
    logic                    sel_pyld_tlast;
    logic                    sel_pyld_tvalid;

    logic ctxt_phase;
    logic pyld_phase;
    logic ctxt_fire;
    logic pyld_fire;

    assign req = s_ctxt_tvalid & en_mask;

    difi_rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req  (req),
        .ptr  (rr_ptr_q),
        .pick (pick_oh),
        .idx  (pick_idx),
        .vld  (pick_vld)
    );

    // AND-OR select of the granted requester; grant_q is zero in IDLE, so nothing leaks through.
    always_comb begin
        sel_ctxt_tdata  = '0;
        sel_ctxt_tuser  = '0;
        sel_ctxt_tlast  = 1'b0;
        sel_ctxt_tvalid = 1'b0;
        sel_pyld_tdata  = '0;
        sel_pyld_tkeep  = 1'b0;
        sel_pyld_tlast  = 1'b0;
        sel_pyld_tvalid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_ctxt_tdata  |= {CHDR_W{grant_q[i]}} & s_ctxt_tdata[i*CHDR_W +: CHDR_W];
            sel_ctxt_tuser  |= {CTXT_TUSER_W{grant_q[i]}} & s_ctxt_tuser[i*CTXT_TUSER_W +: CTXT_TUSER_W];
            sel_ctxt_tlast  |= grant_q[i] & s_ctxt_tlast[i];
            sel_ctxt_tvalid |= grant_q[i] & s_ctxt_tvalid[i];
            sel_pyld_tdata  |= {ITEM_W{grant_q[i]}} & s_pyld_tdata[i*ITEM_W +: ITEM_W];
            sel_pyld_tkeep  |= grant_q[i] & s_pyld_tkeep[i];
            sel_pyld_tlast  |= grant_q[i] & s_pyld_tlast[i];
            sel_pyld_tvalid |= grant_q[i] & s_pyld_tvalid[i];
        end
    end

    assign ctxt_phase = (state_q == CTXT);
    assign pyld_phase = (state_q == PYLD);

    // Each stream is gated by its phase so context and payload never overlap on the output.
    assign m_ctxt_tdata  = {CHDR_W{ctxt_phase}} & sel_ctxt_tdata;
    assign m_ctxt_tuser  = {CTXT_TUSER_W{ctxt_phase}} & sel_ctxt_tuser;
    assign m_ctxt_tlast  = ctxt_phase & sel_ctxt_tlast;
    assign m_ctxt_tvalid = ctxt_phase & sel_ctxt_tvalid;
    assign m_pyld_tdata  = {ITEM_W{pyld_phase}} & sel_pyld_tdata;
    assign m_pyld_tkeep  = pyld_phase & sel_pyld_tkeep;
    assign m_pyld_tlast  = pyld_phase & sel_pyld_tlast;
    assign m_pyld_tvalid = pyld_phase & sel_pyld_tvalid;

    assign s_ctxt_tready = grant_q & {N_REQ{ctxt_phase & m_ctxt_tready}};
    assign s_pyld_tready = grant_q & {N_REQ{pyld_phase & m_pyld_tready}};

    assign ctxt_fire = m_ctxt_tvalid & m_ctxt_tready;
    assign pyld_fire = m_pyld_tvalid & m_pyld_tready;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d  = pick_oh;
                    rr_ptr_d = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
                    state_d  = CTXT;
                end
            end
            CTXT: begin
                if (ctxt_fire && m_ctxt_tlast) begin
                    state_d = PYLD;
                end
            end
            PYLD: begin
                if (pyld_fire && m_pyld_tlast) begin
                    pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                    grant_d   = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge axis_data_clk or negedge axis_data_rst_n) begin
        if (!axis_data_rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            pkt_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the values from before this edge.
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = (state_q != IDLE);
    assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_difi_pkt_arbiter.sv
// Directed scenarios with randomized packet contents, checked every cycle against a packet-level model.
module tb_difi_pkt_arbiter;
    import difi_pkg::*;

    localparam int N  = 2;
    localparam int CW = 64;
    localparam int IW = 32;
    localparam int KW = 32;

    typedef struct packed {
        logic [CW-1:0] data;
        logic [3:0]    user;
        logic          last;
    } cbeat_t;

    typedef struct packed {
        logic [IW-1:0] data;
        logic          keep;
        logic          last;
    } pbeat_t;

    logic               axis_data_clk = 1'b0;
    logic               axis_data_rst_n;
    logic [N-1:0]       en_mask;
    logic [N*CW-1:0]    s_ctxt_tdata;
    logic [N*4-1:0]     s_ctxt_tuser;
    logic [N-1:0]       s_ctxt_tlast, s_ctxt_tvalid, s_ctxt_tready;
    logic [N*IW-1:0]    s_pyld_tdata;
    logic [N-1:0]       s_pyld_tkeep, s_pyld_tlast, s_pyld_tvalid, s_pyld_tready;
    logic [CW-1:0]      m_ctxt_tdata;
    logic [3:0]         m_ctxt_tuser;
    logic               m_ctxt_tlast, m_ctxt_tvalid, m_ctxt_tready;
    logic [IW-1:0]      m_pyld_tdata;
    logic               m_pyld_tkeep, m_pyld_tlast, m_pyld_tvalid, m_pyld_tready;
    logic [N-1:0]       grant;
    logic               busy;
    logic [KW-1:0]      pkt_cnt;

    always #5 axis_data_clk = ~axis_data_clk;

    difi_pkt_arbiter #(.N_REQ(N), .CHDR_W(CW), .ITEM_W(IW), .CNT_W(KW)) dut (
        .axis_data_clk   (axis_data_clk),
        .axis_data_rst_n (axis_data_rst_n),
        .en_mask         (en_mask),
        .s_ctxt_tdata    (s_ctxt_tdata),
        .s_ctxt_tuser    (s_ctxt_tuser),
        .s_ctxt_tlast    (s_ctxt_tlast),
        .s_ctxt_tvalid   (s_ctxt_tvalid),
        .s_ctxt_tready   (s_ctxt_tready),
        .s_pyld_tdata    (s_pyld_tdata),
        .s_pyld_tkeep    (s_pyld_tkeep),
        .s_pyld_tlast    (s_pyld_tlast),
        .s_pyld_tvalid   (s_pyld_tvalid),
        .s_pyld_tready   (s_pyld_tready),
        .m_ctxt_tdata    (m_ctxt_tdata),
        .m_ctxt_tuser    (m_ctxt_tuser),
        .m_ctxt_tlast    (m_ctxt_tlast),
        .m_ctxt_tvalid   (m_ctxt_tvalid),
        .m_ctxt_tready   (m_ctxt_tready),
        .m_pyld_tdata    (m_pyld_tdata),
        .m_pyld_tkeep    (m_pyld_tkeep),
        .m_pyld_tlast    (m_pyld_tlast),
        .m_pyld_tvalid   (m_pyld_tvalid),
        .m_pyld_tready   (m_pyld_tready),
        .grant           (grant),
        .busy            (busy),
        .pkt_cnt         (pkt_cnt)
    );

    // Source queues per requester and the packet-level reference model.
    cbeat_t      cq[N][$];
    pbeat_t      pq[N][$];
    int          owner     = -1;
    bit          in_pyld   = 1'b0;
    int          rr        = 0;
    int unsigned cnt       = 0;
    int          ready_pct = 100;
    int          pkt_seq   = 0;
    string       cur_test  = "init";

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;

    logic [N-1:0] prev_grant = '0;
    logic [N-1:0] last_grant = '0;
    int           grant01_cycles = 0;
    int           idle_pending   = 0;
    int           dut_glog[$];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [143:0] dut_obs();
        return {grant, busy, m_ctxt_tvalid, m_ctxt_tdata, m_ctxt_tuser, m_ctxt_tlast,
                m_pyld_tvalid, m_pyld_tdata, m_pyld_tkeep, m_pyld_tlast,
                s_ctxt_tready, s_pyld_tready, pkt_cnt};
    endfunction

    function automatic bit pending();
        for (int i = 0; i < N; i++)
            if (en_mask[i] && cq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit drained();
        return (owner < 0) && !pending();
    endfunction

    task automatic push_pkt(input int r, input int nc, input int np);
        cbeat_t cb;
        pbeat_t pb;
        for (int b = 0; b < nc; b++) begin
            cb.data = {8'(r), 8'(pkt_seq), 16'(b), $urandom()};
            cb.user = 4'($urandom());
            cb.last = (b == nc - 1);
            cq[r].push_back(cb);
        end
        for (int b = 0; b < np; b++) begin
            pb.data = {4'(r), 8'(pkt_seq), 8'(b), 12'($urandom())};
            pb.keep = 1'($urandom());
            pb.last = (b == np - 1);
            pq[r].push_back(pb);
        end
        pkt_seq++;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (cq[i].size() > 0) begin
                s_ctxt_tvalid[i]          = 1'b1;
                s_ctxt_tdata[i*CW +: CW]  = cq[i][0].data;
                s_ctxt_tuser[i*4 +: 4]    = cq[i][0].user;
                s_ctxt_tlast[i]           = cq[i][0].last;
            end else begin
                s_ctxt_tvalid[i]          = 1'b0;
                s_ctxt_tdata[i*CW +: CW]  = '0;
                s_ctxt_tuser[i*4 +: 4]    = '0;
                s_ctxt_tlast[i]           = 1'b0;
            end
            if (pq[i].size() > 0) begin
                s_pyld_tvalid[i]          = 1'b1;
                s_pyld_tdata[i*IW +: IW]  = pq[i][0].data;
                s_pyld_tkeep[i]           = pq[i][0].keep;
                s_pyld_tlast[i]           = pq[i][0].last;
            end else begin
                s_pyld_tvalid[i]          = 1'b0;
                s_pyld_tdata[i*IW +: IW]  = '0;
                s_pyld_tkeep[i]           = 1'b0;
                s_pyld_tlast[i]           = 1'b0;
            end
        end
        m_ctxt_tready = (int'($urandom_range(99)) < ready_pct);
        m_pyld_tready = (int'($urandom_range(99)) < ready_pct);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            cq[i].delete();
            pq[i].delete();
        end
        owner   = -1;
        in_pyld = 1'b0;
        rr      = 0;
        cnt     = 0;
    endtask

    // Compare DUT outputs with the model's expectation for this cycle, then advance the model.
    task automatic sample_and_model();
        logic [N-1:0]  e_grant, e_cr, e_pr, req;
        logic          e_busy, e_cv, e_cl, e_pv, e_pk, e_pl;
        logic [CW-1:0] e_cd;
        logic [3:0]    e_cu;
        logic [IW-1:0] e_pd;
        int            pick;
        bit            lst;
        e_grant = '0; e_cr = '0; e_pr = '0; req = '0;
        e_busy = 1'b0; e_cv = 1'b0; e_cl = 1'b0; e_pv = 1'b0; e_pk = 1'b0; e_pl = 1'b0;
        e_cd = '0; e_cu = '0; e_pd = '0;
        pick = -1;
        if (owner < 0) begin
            req = s_ctxt_tvalid & en_mask;
            for (int k = 0; k < N; k++)
                if (pick < 0 && req[(rr + k) % N]) pick = (rr + k) % N;
        end else begin
            e_grant[owner] = 1'b1;
            e_busy         = 1'b1;
            if (!in_pyld) begin
                e_cv        = s_ctxt_tvalid[owner];
                e_cd        = s_ctxt_tdata[owner*CW +: CW];
                e_cu        = s_ctxt_tuser[owner*4 +: 4];
                e_cl        = s_ctxt_tlast[owner];
                e_cr[owner] = m_ctxt_tready;
            end else begin
                e_pv        = s_pyld_tvalid[owner];
                e_pd        = s_pyld_tdata[owner*IW +: IW];
                e_pk        = s_pyld_tkeep[owner];
                e_pl        = s_pyld_tlast[owner];
                e_pr[owner] = m_pyld_tready;
            end
        end
        check(cur_test, dut_obs(),
              {e_grant, e_busy, e_cv, e_cd, e_cu, e_cl, e_pv, e_pd, e_pk, e_pl, e_cr, e_pr, KW'(cnt)});

        if (grant == 2'b01) grant01_cycles++;
        if (prev_grant == '0 && grant != '0) dut_glog.push_back(grant[1] ? 1 : 0);
        if (!busy && pending()) idle_pending++;
        prev_grant = grant;
        last_grant = grant;

        if (owner < 0) begin
            if (pick >= 0) begin
                owner   = pick;
                rr      = (pick + 1) % N;
                in_pyld = 1'b0;
            end
        end else if (!in_pyld) begin
            if (s_ctxt_tvalid[owner] && m_ctxt_tready) begin
                lst = cq[owner][0].last;
                void'(cq[owner].pop_front());
                if (lst) in_pyld = 1'b1;
            end
        end else begin
            if (s_pyld_tvalid[owner] && m_pyld_tready) begin
                lst = pq[owner][0].last;
                void'(pq[owner].pop_front());
                if (lst) begin
                    cnt++;
                    owner = -1;
                end
            end
        end
    endtask

    // Starts and ends on a falling edge.
    task automatic cycle();
        drive();
        #2;
        sample_and_model();
        @(posedge axis_data_clk);
        @(negedge axis_data_clk);
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int c = 0;
        while (!drained() && c < max_cycles) begin
            cycle();
            c++;
        end
        check({tag, "_drain"}, 256'(drained()), 256'd1);
    endtask

    task automatic do_reset();
        axis_data_rst_n = 1'b0;
        model_reset();
        drive();
        @(negedge axis_data_clk);
        @(negedge axis_data_clk);
        axis_data_rst_n = 1'b1;
        prev_grant = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        axis_data_rst_n = 1'b0;
        en_mask         = '1;
        model_reset();
        drive();

        // 1. Reset holds every ready and valid low even with all sources valid.
        cur_test = "t1_reset";
        @(negedge axis_data_clk);
        s_ctxt_tvalid = '1;
        s_pyld_tvalid = '1;
        m_ctxt_tready = 1'b1;
        m_pyld_tready = 1'b1;
        #2;
        check("t1_s_ctxt_tready", s_ctxt_tready, 0);
        check("t1_s_pyld_tready", s_pyld_tready, 0);
        check("t1_m_valids", {m_ctxt_tvalid, m_pyld_tvalid}, 0);
        check("t1_pkt_cnt", pkt_cnt, 0);
        check("t1_grant_busy", {grant, busy}, 0);
        @(posedge axis_data_clk);
        #1;
        check("t1_after_edge", dut_obs(), 0);
        @(negedge axis_data_clk);
        drive();
        axis_data_rst_n = 1'b1;

        // 2. Single requester, 2 context + 8 payload beats, no backpressure.
        cur_test = "t2_single";
        push_pkt(0, 2, 8);
        grant01_cycles = 0;
        drain("t2", 100);
        cycle();
        check("t2_grant_cycles", grant01_cycles, 10);
        check("t2_pkt_cnt", pkt_cnt, 1);
        check("t2_busy_fell", busy, 0);

        // 3. Contention: both requesters always valid, 6 packets each.
        cur_test = "t3_contention";
        do_reset();
        for (int p = 0; p < 6; p++) begin
            push_pkt(0, $urandom_range(1, 3), $urandom_range(1, 6));
            push_pkt(1, $urandom_range(1, 3), $urandom_range(1, 6));
        end
        dut_glog.delete();
        drain("t3", 2000);
        cycle();
        check("t3_grant_count", dut_glog.size(), 12);
        for (int k = 0; k < 12 && k < dut_glog.size(); k++)
            check($sformatf("t3_grant_order_%0d", k), dut_glog[k], k % 2);
        check("t3_pkt_cnt", pkt_cnt, 12);

        // 4. Random 30% ready on both outputs, long payload from requester 1.
        cur_test = "t4_backpressure";
        ready_pct = 30;
        push_pkt(1, 2, 100);
        for (int p = 0; p < 3; p++) push_pkt(0, $urandom_range(1, 3), $urandom_range(1, 8));
        idle_pending = 0;
        drain("t4", 5000);
        ready_pct = 100;
        cycle();
        check("t4_one_bubble_per_pkt", idle_pending, 4);
        check("t4_pkt_cnt", pkt_cnt, 16);

        // 5. Masking: only requester 1 enabled; mask cleared while its packet is in flight.
        cur_test = "t5_mask";
        en_mask = 2'b10;
        push_pkt(0, 1, 2);
        push_pkt(1, 2, 6);
        dut_glog.delete();
        c = 0;
        while (!(owner == 1 && in_pyld) && c < 50) begin
            cycle();
            c++;
        end
        check("t5_reached_pyld", 256'(owner == 1 && in_pyld), 256'd1);
        en_mask = 2'b00;
        c = 0;
        while (owner >= 0 && c < 50) begin
            cycle();
            c++;
        end
        for (int k = 0; k < 4; k++) cycle();
        check("t5_grants_masked", dut_glog.size(), 1);
        check("t5_first_grant", dut_glog[0], 1);
        check("t5_pkt_cnt", pkt_cnt, 17);
        check("t5_idle_masked", {grant, busy}, 0);
        en_mask = 2'b11;
        drain("t5", 100);
        cycle();
        check("t5_grants_all", dut_glog.size(), 2);
        check("t5_second_grant", dut_glog[1], 0);
        check("t5_pkt_cnt_final", pkt_cnt, 18);

        // 6. Reset while payload beat 3 is presented; rr pointer restarts at 0.
        cur_test = "t6_mid_reset";
        do_reset();
        push_pkt(0, 1, 8);
        c = 0;
        while (!(in_pyld && pq[0].size() == 5) && c < 50) begin
            cycle();
            c++;
        end
        drive();
        #2;
        check("t6_in_pyld_before_rst", {grant, busy, m_pyld_tvalid}, 4'b0111);
        axis_data_rst_n = 1'b0;
        #1;
        check("t6_outputs_drop", dut_obs(), 0);
        model_reset();
        @(negedge axis_data_clk);
        drive();
        @(negedge axis_data_clk);
        axis_data_rst_n = 1'b1;
        prev_grant = '0;
        push_pkt(0, 1, 2);
        push_pkt(1, 1, 2);
        dut_glog.delete();
        cycle();
        cycle();
        check("t6_grant_after_rst", last_grant, 2'b01);
        drain("t6", 100);
        cycle();
        check("t6_grants", dut_glog.size(), 2);
        check("t6_order", {dut_glog[0][1:0], dut_glog[1][1:0]}, 4'b0001);
        check("t6_pkt_cnt", pkt_cnt, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
